set_associative_cache: RTL and testbench

Parametrised N-way set-associative, write-through, no-write-allocate cache with true-LRU replacement and valid/ready handshakes on both the CPU side and the memory side. It generalises the fixed two-way cache: way count, set count and widths are parameters, and a request/fill state machine replaces single-cycle lookup. It sits between the CPU load/store path and main data memory.

---
 rtl/set_associative_cache.sv | 177 +++++++++++++++++
 tb/tb_set_associative_cache.sv | 208 ++++++++++++++++++++
 2 files changed

// File: rtl/set_associative_cache.sv
// N-way set-associative, write-through, no-write-allocate cache with true-LRU replacement.
// Latency: read hit responds 2 cycles after acceptance; miss/write responds 1 cycle after mem_ack_i.
// Backpressure: one request in flight; req_ready_o is high only in IDLE, memory request held until ack.
module set_associative_cache #(
    parameter int DATA_WIDTH = 32,
    parameter int ADDR_WIDTH = 32,
    parameter int WAYS       = 2,
    parameter int SETS       = 8
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic                  req_valid_i,
    output logic                  req_ready_o,
    input  logic                  req_we_i,
    input  logic [ADDR_WIDTH-1:0] addressWord_i,
    input  logic [DATA_WIDTH-1:0] dataWord_i,
    output logic                  rsp_valid_o,
    output logic [DATA_WIDTH-1:0] dataWord_o,
    output logic                  hit_o,
    output logic                  mem_req_o,
    output logic                  mem_we_o,
    output logic [ADDR_WIDTH-1:0] mem_addr_o,
    output logic [DATA_WIDTH-1:0] mem_wdata_o,
    input  logic                  mem_ack_i,
    input  logic [DATA_WIDTH-1:0] mem_rdata_i
);

    localparam int IW = $clog2(SETS);
    localparam int WW = $clog2(WAYS);
    localparam int AW = ADDR_WIDTH - 2;   // word address width
    localparam int TW = AW - IW;          // tag width

    typedef enum logic [1:0] {
        S_IDLE   = 2'd0,
        S_LOOKUP = 2'd1,
        S_MEM    = 2'd2,
        S_RESP   = 2'd3
    } state_t;

    state_t                state_q;
    logic [AW-1:0]         addr_q;
    logic [DATA_WIDTH-1:0] wdata_q;
    logic                  we_q;
    logic                  hit_q;
    logic [DATA_WIDTH-1:0] rdata_q;

    logic                  valid_q [SETS][WAYS];
    logic [TW-1:0]         tag_q   [SETS][WAYS];
    logic [DATA_WIDTH-1:0] data_q  [SETS][WAYS];
    logic [WW-1:0]         age_q   [SETS][WAYS];

    // Byte-offset bits carry no information for a word-per-line cache.
    logic unused_byte_offset;
    assign unused_byte_offset = ^addressWord_i[1:0];

    logic [IW-1:0] idx;
    logic [TW-1:0] tag_l;
    assign idx   = addr_q[IW-1:0];
    assign tag_l = addr_q[AW-1:IW];

    logic          lk_hit;
    logic [WW-1:0] lk_way;
    logic          vic_inv;
    logic [WW-1:0] vic_way;
    logic [WW-1:0] tch_way;
    logic [WW-1:0] age_nxt [WAYS];

    // Tag match across the indexed set, and victim choice: lowest invalid way, else the oldest.
    always_comb begin
        lk_hit  = 1'b0;
        lk_way  = '0;
        vic_inv = 1'b0;
        vic_way = '0;
        for (int w = 0; w < WAYS; w++) begin
            if (!lk_hit && valid_q[idx][w] && (tag_q[idx][w] == tag_l)) begin
                lk_hit = 1'b1;
                lk_way = WW'(w);
            end
        end
        for (int w = 0; w < WAYS; w++) begin
            if (!vic_inv && !valid_q[idx][w]) begin
                vic_inv = 1'b1;
                vic_way = WW'(w);
            end
        end
        if (!vic_inv) begin
            for (int w = 0; w < WAYS; w++) begin
                if (age_q[idx][w] == WW'(WAYS - 1)) begin
                    vic_way = WW'(w);
                end
            end
        end
    end

    // Ages of the indexed set after touching the hit way (LOOKUP) or the victim (MEM fill).
    always_comb begin
        tch_way = (state_q == S_MEM) ? vic_way : lk_way;
        for (int w = 0; w < WAYS; w++) begin
            age_nxt[w] = age_q[idx][w];
            if (age_q[idx][w] < age_q[idx][tch_way]) begin
                age_nxt[w] = age_q[idx][w] + 1'b1;
            end
        end
        age_nxt[tch_way] = '0;
    end

    // Request FSM plus line storage and LRU updates.
    always_ff @(posedge clk) begin
        if (rst) begin
            state_q <= S_IDLE;
            addr_q  <= '0;
            wdata_q <= '0;
            we_q    <= 1'b0;
            hit_q   <= 1'b0;
            rdata_q <= '0;
            for (int s = 0; s < SETS; s++) begin
                for (int w = 0; w < WAYS; w++) begin
                    valid_q[s][w] <= 1'b0;
                    age_q[s][w]   <= WW'(w);
                end
            end
        end else begin
            case (state_q)
                S_IDLE: begin
                    if (req_valid_i) begin
                        addr_q  <= addressWord_i[ADDR_WIDTH-1:2];
                        wdata_q <= dataWord_i;
                        we_q    <= req_we_i;
                        state_q <= S_LOOKUP;
                    end
                end
                S_LOOKUP: begin
                    hit_q <= lk_hit;
                    if (lk_hit) begin
                        if (we_q) begin
                            data_q[idx][lk_way] <= wdata_q;
                        end else begin
                            rdata_q <= data_q[idx][lk_way];
                        end
                        for (int w = 0; w < WAYS; w++) begin
                            age_q[idx][w] <= age_nxt[w];
                        end
                    end
                    // Writes always go through to memory; only read hits skip it.
                    state_q <= (lk_hit && !we_q) ? S_RESP : S_MEM;
                end
                S_MEM: begin
                    if (mem_ack_i) begin
                        if (!we_q) begin
                            valid_q[idx][vic_way] <= 1'b1;
                            tag_q[idx][vic_way]   <= tag_l;
                            data_q[idx][vic_way]  <= mem_rdata_i;
                            rdata_q               <= mem_rdata_i;
                            for (int w = 0; w < WAYS; w++) begin
                                age_q[idx][w] <= age_nxt[w];
                            end
                        end
                        state_q <= S_RESP;
                    end
                end
                default: begin
                    state_q <= S_IDLE;
                end
            endcase
        end
    end

    assign req_ready_o = (state_q == S_IDLE);
    assign rsp_valid_o = (state_q == S_RESP);
    assign mem_req_o   = (state_q == S_MEM);
    assign mem_we_o    = (state_q == S_MEM) && we_q;
    assign mem_addr_o  = {addr_q, 2'b00};
    assign mem_wdata_o = wdata_q;
    assign dataWord_o  = rdata_q;
    assign hit_o       = hit_q;

endmodule

// File: tb/tb_set_associative_cache.sv
// Directed bench for set_associative_cache (WAYS=2, SETS=4) with a response scoreboard.
// Inputs change on the falling edge; outputs are sampled on the falling edge.
// Memory side is driven by the stimulus sequence with explicit ack delays.
module tb_set_associative_cache;

    logic        clk;
    logic        rst;
    logic        req_valid_i;
    logic        req_ready_o;
    logic        req_we_i;
    logic [31:0] addressWord_i;
    logic [31:0] dataWord_i;
    logic        rsp_valid_o;
    logic [31:0] dataWord_o;
    logic        hit_o;
    logic        mem_req_o;
    logic        mem_we_o;
    logic [31:0] mem_addr_o;
    logic [31:0] mem_wdata_o;
    logic        mem_ack_i;
    logic [31:0] mem_rdata_i;

    int checks = 0;
    int errors = 0;

    typedef struct packed {
        logic        hit;
        logic [31:0] data;
        logic        chk_data;
    } exp_t;

    exp_t rsp_q [$];

    set_associative_cache #(
        .DATA_WIDTH(32),
        .ADDR_WIDTH(32),
        .WAYS      (2),
        .SETS      (4)
    ) dut (
        .clk          (clk),
        .rst          (rst),
        .req_valid_i  (req_valid_i),
        .req_ready_o  (req_ready_o),
        .req_we_i     (req_we_i),
        .addressWord_i(addressWord_i),
        .dataWord_i   (dataWord_i),
        .rsp_valid_o  (rsp_valid_o),
        .dataWord_o   (dataWord_o),
        .hit_o        (hit_o),
        .mem_req_o    (mem_req_o),
        .mem_we_o     (mem_we_o),
        .mem_addr_o   (mem_addr_o),
        .mem_wdata_o  (mem_wdata_o),
        .mem_ack_i    (mem_ack_i),
        .mem_rdata_i  (mem_rdata_i)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    // Scoreboard: every response pulse pops the oldest expectation.
    always @(negedge clk) begin
        if (rsp_valid_o === 1'b1) begin
            checks++;
            assert (rsp_q.size() != 0) else begin
                errors++;
                $error("FAIL unexpected_rsp observed=%0d expected=%0d", 1, 0);
            end
            if (rsp_q.size() != 0) begin
                exp_t e;
                e = rsp_q.pop_front();
                chk("rsp_hit", {31'd0, hit_o}, {31'd0, e.hit});
                if (e.chk_data) chk("rsp_data", dataWord_o, e.data);
            end
        end
    end

    // One complete transaction: acceptance, lookup, optional memory phase, response.
    task automatic do_req(input logic we, input logic [31:0] addr, input logic [31:0] wdata,
                          input logic exp_hit, input logic [31:0] exp_data,
                          input logic exp_mem, input int wait_cyc,
                          input logic [31:0] mdata, input logic hold);
        exp_t e;
        @(negedge clk);
        chk("idle_ready", {31'd0, req_ready_o}, 32'd1);
        req_valid_i   = 1'b1;
        req_we_i      = we;
        addressWord_i = addr;
        dataWord_i    = wdata;
        e.hit = exp_hit; e.data = exp_data; e.chk_data = !we;
        rsp_q.push_back(e);
        @(negedge clk);   // LOOKUP
        if (!hold) req_valid_i = 1'b0;
        chk("lookup_ready",  {31'd0, req_ready_o}, 32'd0);
        chk("lookup_memreq", {31'd0, mem_req_o},   32'd0);
        @(negedge clk);   // first cycle after LOOKUP
        if (exp_mem) begin
            for (int i = 0; i <= wait_cyc; i++) begin
                chk("mem_req",   {31'd0, mem_req_o},   32'd1);
                chk("mem_we",    {31'd0, mem_we_o},    {31'd0, we});
                chk("mem_addr",  mem_addr_o,           addr & 32'hFFFF_FFFC);
                chk("mem_wdata", mem_wdata_o,          wdata);
                chk("mem_ready", {31'd0, req_ready_o}, 32'd0);
                chk("mem_norsp", {31'd0, rsp_valid_o}, 32'd0);
                if (i == wait_cyc) begin
                    mem_ack_i   = 1'b1;
                    mem_rdata_i = mdata;
                    req_valid_i = 1'b0;
                end
                @(negedge clk);
            end
            mem_ack_i = 1'b0;
        end
        chk("rsp_pulse",  {31'd0, rsp_valid_o}, 32'd1);
        chk("rsp_memreq", {31'd0, mem_req_o},   32'd0);
        chk("rsp_ready",  {31'd0, req_ready_o}, 32'd0);
        @(negedge clk);
        chk("rsp_end",    {31'd0, rsp_valid_o}, 32'd0);
        chk("back_ready", {31'd0, req_ready_o}, 32'd1);
    endtask

    initial begin
        rst           = 1'b1;
        req_valid_i   = 1'b0;
        req_we_i      = 1'b0;
        addressWord_i = '0;
        dataWord_i    = '0;
        mem_ack_i     = 1'b0;
        mem_rdata_i   = '0;
        repeat (2) @(negedge clk);
        rst = 1'b0;

        // Reset state.
        chk("rst_ready", {31'd0, req_ready_o}, 32'd1);
        chk("rst_rsp",   {31'd0, rsp_valid_o}, 32'd0);
        chk("rst_memreq",{31'd0, mem_req_o},   32'd0);
        chk("rst_memwe", {31'd0, mem_we_o},    32'd0);
        chk("rst_data",  dataWord_o,           32'd0);
        chk("rst_hit",   {31'd0, hit_o},       32'd0);
        chk("rst_maddr", mem_addr_o,           32'd0);
        chk("rst_mwdata",mem_wdata_o,          32'd0);

        // Cold miss then hit (all of 0x10/0x20/0x30/0x40 map to set 0).
        do_req(1'b0, 32'h10, 32'h0, 1'b0, 32'hDEADBEEF, 1'b1, 0, 32'hDEADBEEF, 1'b0);
        do_req(1'b0, 32'h10, 32'h0, 1'b1, 32'hDEADBEEF, 1'b0, 0, 32'h0,        1'b0);

        // LRU eviction: 0x20 is least recent when 0x30 arrives.
        do_req(1'b0, 32'h20, 32'h0, 1'b0, 32'h20202020, 1'b1, 1, 32'h20202020, 1'b0);
        do_req(1'b0, 32'h10, 32'h0, 1'b1, 32'hDEADBEEF, 1'b0, 0, 32'h0,        1'b0);
        do_req(1'b0, 32'h30, 32'h0, 1'b0, 32'h30303030, 1'b1, 0, 32'h30303030, 1'b0);
        do_req(1'b0, 32'h10, 32'h0, 1'b1, 32'hDEADBEEF, 1'b0, 0, 32'h0,        1'b0);
        do_req(1'b0, 32'h20, 32'h0, 1'b0, 32'h20202021, 1'b1, 2, 32'h20202021, 1'b0);

        // Write hit updates the line and goes through to memory.
        do_req(1'b1, 32'h10, 32'h12345678, 1'b1, 32'h0, 1'b1, 0, 32'h0, 1'b0);
        do_req(1'b0, 32'h10, 32'h0, 1'b1, 32'h12345678, 1'b0, 0, 32'h0, 1'b0);

        // Write miss does not allocate.
        do_req(1'b1, 32'h40, 32'hCAFEF00D, 1'b0, 32'h0, 1'b1, 0, 32'h0, 1'b0);
        do_req(1'b0, 32'h40, 32'h0, 1'b0, 32'h40404040, 1'b1, 0, 32'h40404040, 1'b0);

        // Slow memory with req_valid_i held high (set 1, leaves 0x10 cached).
        do_req(1'b0, 32'h54, 32'hA5A5A5A5, 1'b0, 32'h54545454, 1'b1, 5, 32'h54545454, 1'b1);
        do_req(1'b0, 32'h10, 32'h0, 1'b1, 32'h12345678, 1'b0, 0, 32'h0, 1'b0);

        // Reset while a memory read is outstanding.
        @(negedge clk);
        req_valid_i   = 1'b1;
        req_we_i      = 1'b0;
        addressWord_i = 32'h18;
        @(negedge clk);
        req_valid_i = 1'b0;
        @(negedge clk);
        chk("pre_rst_memreq", {31'd0, mem_req_o}, 32'd1);
        rst = 1'b1;
        @(negedge clk);
        chk("midrst_memreq", {31'd0, mem_req_o},   32'd0);
        chk("midrst_ready",  {31'd0, req_ready_o}, 32'd1);
        chk("midrst_rsp",    {31'd0, rsp_valid_o}, 32'd0);
        rst         = 1'b0;
        mem_ack_i   = 1'b1;
        mem_rdata_i = 32'hBADBAD00;
        @(negedge clk);
        mem_ack_i = 1'b0;
        for (int i = 0; i < 3; i++) begin
            chk("late_ack_rsp",    {31'd0, rsp_valid_o}, 32'd0);
            chk("late_ack_memreq", {31'd0, mem_req_o},   32'd0);
            @(negedge clk);
        end
        // Contents were invalidated by reset.
        do_req(1'b0, 32'h10, 32'h0, 1'b0, 32'h11111111, 1'b1, 0, 32'h11111111, 1'b0);

        repeat (2) @(negedge clk);
        chk("sb_empty", rsp_q.size(), 32'd0);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
